hazard_stall_controller: RTL and testbench



---
 rtl/hazard_stall_controller.sv | 111 +++++++++++
 tb/tb_hazard_stall_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline enables/flushes for load-use, taken branches and
// data-memory waits, with a sticky memory timeout and saturating perf counters.
module hazard_stall_controller #(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             MEMWB_flush,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TIMEOUT = 2'b10} state_t;

    localparam logic [7:0] MW = 8'(MAX_WAIT);

    state_t           r_state, w_next;
    logic [7:0]       r_wait_cnt, w_wait_nxt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall, r_flush;
    logic             w_load_use, w_mem_block, w_blocked, w_lu_stall, w_flush_evt;

    assign w_load_use  = EX_MemRead && (EX_rd != '0) &&
                         ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
    assign w_mem_block = MEM_req && !MEM_ready;
    assign w_blocked   = (r_state == RUN) ? w_mem_block : !MEM_ready;
    // A taken branch kills the ID instruction, so its load-use hazard is moot.
    assign w_lu_stall  = w_load_use && !EX_BranchTaken;

    always_comb begin
        w_next      = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_flush_evt = 1'b0;
        PC_en       = 1'b0;
        IFID_en     = 1'b0;
        IDEX_en     = 1'b0;
        EXMEM_en    = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        MEMWB_flush = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (w_blocked) begin
                        MEMWB_flush = 1'b1;
                        if (r_state == RUN) begin
                            w_next     = MEM_WAIT;
                            w_wait_nxt = 8'd1;
                        end else if (r_wait_cnt == MW) begin
                            w_next = TIMEOUT;
                        end else begin
                            w_wait_nxt = r_wait_cnt + 8'd1;
                        end
                    end else begin
                        w_next      = RUN;
                        PC_en       = !w_lu_stall;
                        IFID_en     = !w_lu_stall;
                        IDEX_en     = 1'b1;
                        EXMEM_en    = 1'b1;
                        IFID_flush  = EX_BranchTaken;
                        IDEX_flush  = EX_BranchTaken || w_load_use;
                        w_flush_evt = EX_BranchTaken;
                    end
                end
                TIMEOUT: MEMWB_flush = 1'b1;
                default: w_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall       <= '0;
            r_flush       <= '0;
        end else begin
            r_state       <= w_next;
            r_wait_cnt    <= w_wait_nxt;
            r_mem_timeout <= r_mem_timeout || (w_next == TIMEOUT);
            if (!PC_en && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
            if (w_flush_evt && r_flush != '1)
                r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign state        = r_state;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed checks of hazard_stall_controller, with a second
// 4-bit-counter instance sharing the stimulus to exercise counter saturation.
module tb_hazard_stall_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic        ID_uses_rs1 = 0, ID_uses_rs2 = 0, EX_MemRead = 0, EX_BranchTaken = 0;
    logic        MEM_req = 0, MEM_ready = 0;
    logic        PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, MEMWB_flush;
    logic        mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cycles, flush_count;
    logic        s_pc, s_ifid, s_idex, s_exmem, s_fif, s_fid, s_fmw, s_to;
    logic [1:0]  s_state;
    logic [3:0]  s_stall, s_flush;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hazard_stall_controller dut (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_rd(EX_rd),
        .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .MEMWB_flush(MEMWB_flush),
        .mem_timeout(mem_timeout), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_stall_controller #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_rd(EX_rd),
        .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .PC_en(s_pc), .IFID_en(s_ifid), .IDEX_en(s_idex), .EXMEM_en(s_exmem),
        .IFID_flush(s_fif), .IDEX_flush(s_fid), .MEMWB_flush(s_fmw),
        .mem_timeout(s_to), .state(s_state),
        .stall_cycles(s_stall), .flush_count(s_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [3:0] en, input logic [2:0] fl);
        chk({tag, "_en"}, {28'd0, PC_en, IFID_en, IDEX_en, EXMEM_en}, {28'd0, en});
        chk({tag, "_fl"}, {29'd0, IFID_flush, IDEX_flush, MEMWB_flush}, {29'd0, fl});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {ID_rs1, ID_rs2, EX_rd} = '0;
        {ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_BranchTaken, MEM_req, MEM_ready} = '0;
        #1;
    endtask

    initial begin
        step(2);
        ctl("rst", 4'b0000, 3'b000);
        chk("rst_state", 32'(state), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_flush", 32'(flush_count), 0);
        chk("rst_to", 32'(mem_timeout), 0);
        rst = 1'b0;
        #1;
        ctl("idle", 4'b1111, 3'b000);

        EX_MemRead = 1; EX_rd = 5; ID_rs2 = 5; ID_uses_rs2 = 1; #1;
        ctl("lu", 4'b0011, 3'b010);
        step(1);
        clear();
        ctl("lu_after", 4'b1111, 3'b000);
        chk("lu_stall", 32'(stall_cycles), 1);

        EX_MemRead = 1; EX_rd = 0; ID_rs2 = 0; ID_uses_rs2 = 1; #1;
        ctl("x0", 4'b1111, 3'b000);
        EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 0; ID_uses_rs2 = 0; #1;
        ctl("nouse", 4'b1111, 3'b000);
        ID_uses_rs1 = 1; #1;
        ctl("lu_rs1", 4'b0011, 3'b010);
        step(1);
        clear();
        chk("lu_rs1_stall", 32'(stall_cycles), 2);

        EX_BranchTaken = 1; EX_MemRead = 1; EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 1; #1;
        ctl("br_lu", 4'b1111, 3'b110);
        step(1);
        clear();
        chk("br_flush", 32'(flush_count), 1);
        chk("br_stall", 32'(stall_cycles), 2);

        MEM_req = 1; MEM_ready = 0; #1;
        ctl("mw_c1", 4'b0000, 3'b001);
        step(1);
        chk("mw_c2_state", 32'(state), 1);
        ctl("mw_c2", 4'b0000, 3'b001);
        step(2);
        chk("mw_c4_state", 32'(state), 1);
        ctl("mw_c4", 4'b0000, 3'b001);
        step(1);
        MEM_ready = 1; EX_BranchTaken = 1; #1;
        chk("mw_c5_state", 32'(state), 1);
        ctl("mw_rel", 4'b1111, 3'b110);
        step(1);
        clear();
        chk("mw_state", 32'(state), 0);
        chk("mw_stall", 32'(stall_cycles), 6);
        chk("mw_flush", 32'(flush_count), 2);

        MEM_req = 1; MEM_ready = 1; #1;
        ctl("grant", 4'b1111, 3'b000);
        step(1);
        clear();
        chk("grant_state", 32'(state), 0);
        chk("grant_stall", 32'(stall_cycles), 6);

        MEM_req = 1; MEM_ready = 0; #1;
        step(15);
        chk("to_pre_state", 32'(state), 1);
        chk("to_pre_flag", 32'(mem_timeout), 0);
        step(1);
        chk("to_state", 32'(state), 2);
        chk("to_flag", 32'(mem_timeout), 1);
        chk("to_stall", 32'(stall_cycles), 22);
        MEM_ready = 1; #1;
        ctl("to_ready", 4'b0000, 3'b001);
        step(1);
        chk("to_stay", 32'(state), 2);
        chk("to_stall2", 32'(stall_cycles), 23);
        chk("sat_stall", 32'(s_stall), 15);
        chk("sat_flush", 32'(s_flush), 2);
        step(3);
        chk("sat_hold", 32'(s_stall), 15);
        chk("s_to_state", 32'(s_state), 2);

        rst = 1; #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_to", 32'(mem_timeout), 0);
        chk("arst_stall", 32'(stall_cycles), 0);
        chk("arst_flush", 32'(flush_count), 0);
        ctl("arst", 4'b0000, 3'b000);
        step(1);
        rst = 0;
        clear();

        MEM_req = 1; MEM_ready = 0; #1;
        step(2);
        chk("mid_state", 32'(state), 1);
        rst = 1; #1;
        chk("mid_rst_state", 32'(state), 0);
        ctl("mid_rst", 4'b0000, 3'b000);
        step(1);
        clear();
        rst = 0; #1;
        ctl("post_rst", 4'b1111, 3'b000);
        chk("post_rst_stall", 32'(stall_cycles), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
